// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the RAM request/response controller.
//   state_e           - controller FSM states
//   MEM_DEPTH_DEFAULT - default number of implemented RAM words
package mem_ctrl_pkg;

  localparam int unsigned MEM_DEPTH_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR,
    RESP
  } state_e;

endpackage

// File: rtl/bidir_bus_drv.sv
// bidir_bus_drv: tristate driver for a shared bidirectional bus.
//   en   in    1      drive dout onto pad when high, else release pad to 'z
//   dout in    Width  value to drive
//   din  out   Width  current pad value (always readable)
//   pad  inout Width  shared bus pin
module bidir_bus_drv #(
  parameter int unsigned Width = 16
) (
  input  logic             en,
  input  logic [Width-1:0] dout,
  output logic [Width-1:0] din,
  inout  wire  [Width-1:0] pad
);

  assign pad = en ? dout : 'z;
  assign din = pad;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: valid/ready request front end for a single-port RAM with a
// registered read and a shared bidirectional data bus.
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/ready/we/addr/wdata  CPU request channel (accepted only in IDLE)
//   rsp_valid/ready/rdata/err      response channel (held until rsp_ready)
//   ram_st, ram_oe, ram_addr       RAM control, decoded from registered state
//   ram_data                       shared RAM data bus, driven only in WR
// Optional feature: define MEM_CTRL_BOUNDS_CHECK_EN to reject addresses
// >= DEPTH with rsp_err=1 and no RAM access; otherwise rsp_err is tied 0.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BitCount = 16,
  parameter int unsigned DEPTH    = MEM_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [BitCount-1:0] req_addr,
  input  logic [BitCount-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BitCount-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                ram_st,
  output logic                ram_oe,
  output logic [BitCount-1:0] ram_addr,
  inout  wire  [BitCount-1:0] ram_data
);

  state_e              state, state_nxt;
  logic [BitCount-1:0] addr_q, wdata_q, rdata_q;
  logic [BitCount-1:0] bus_in;
  logic                err_q;
  logic                oob;
  logic                accept;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  assign oob = (int unsigned'(req_addr) >= DEPTH);
`else
  assign oob = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (oob)         state_nxt = RESP;
          else if (req_we) state_nxt = WR;
          else             state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_CAPT;
      RD_CAPT:  state_nxt = RESP;
      WR:       state_nxt = RESP;
      RESP:     if (rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= oob;
        // A rejected op skips the RAM states, so clear the read data here.
        if (oob) rdata_q <= '0;
      end
      // RAM drives its read buffer while oe is high in RD_CAPT.
      if (state == RD_CAPT) rdata_q <= bus_in;
      if (state == WR)      rdata_q <= '0;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign ram_st    = (state == WR);
  assign ram_oe    = (state == RD_CAPT);
  assign ram_addr  = addr_q;

  bidir_bus_drv #(
    .Width(BitCount)
  ) u_bus (
    .en  (state == WR),
    .dout(wdata_q),
    .din (bus_in),
    .pad (ram_data)
  );

endmodule
